// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// owner encoding and the byte-address range check.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   // True when every byte-address bit above the word-address field is zero.
   function automatic logic addrInRange(input logic [31:0] addr, input int addrWidth);
      return (addr >> (addrWidth + 2)) == 32'd0;
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between CPU and DMA requesters.
// Define DMEM_ARB_RR_EN for round-robin on contention; otherwise CPU has fixed priority.
module dmem_arb_pick
   import dmem_arbiter_pkg::*;
(
   input  logic i_cpuReq,
   input  logic i_dmaReq,
`ifdef DMEM_ARB_RR_EN
   input  logic i_owner,
`endif
   output logic o_winner,
   output logic o_valid
);

   always_comb begin
      o_valid = i_cpuReq | i_dmaReq;
`ifdef DMEM_ARB_RR_EN
      // On contention hand the grant to whoever did not win last time.
      if (i_cpuReq && i_dmaReq) begin
         o_winner = ~i_owner;
      end else begin
         o_winner = i_cpuReq ? OWN_CPU : OWN_DMA;
      end
`else
      o_winner = i_cpuReq ? OWN_CPU : OWN_DMA;
`endif
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store path and a DMA port
// through an IDLE -> ACCESS -> RESP sequencer. DMEM_ARB_RR_EN selects round-robin arbitration.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_LAT    = 1
)(
   input  logic                  clk,
   input  logic                  reset_b,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [31:0]           cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ack,
   output logic                  cpu_stall,
   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [31:0]           dma_addr,
   input  logic [DATA_WIDTH-1:0] dma_wdata,
   output logic [DATA_WIDTH-1:0] dma_rdata,
   output logic                  dma_ack,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  owner,
   output logic                  addr_err
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_owner;
   logic                 r_we;
   logic                 r_oor;

   logic                  w_winner;
   logic                  w_valid;
   logic                  w_selWe;
   logic [31:0]           w_selAddr;
   logic [DATA_WIDTH-1:0] w_selWdata;
   logic                  w_oor;

   dmem_arb_pick u_pick (
      .i_cpuReq (cpu_req),
      .i_dmaReq (dma_req),
`ifdef DMEM_ARB_RR_EN
      .i_owner  (r_owner),
`endif
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   assign w_selWe    = (w_winner == OWN_CPU) ? cpu_we    : dma_we;
   assign w_selAddr  = (w_winner == OWN_CPU) ? cpu_addr  : dma_addr;
   assign w_selWdata = (w_winner == OWN_CPU) ? cpu_wdata : dma_wdata;
   assign w_oor      = ~addrInRange(w_selAddr, ADDR_WIDTH);

   assign owner     = r_owner;
   assign cpu_stall = cpu_req & ~cpu_ack;

   always_ff @(posedge clk) begin
      if (reset_b) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_owner   <= OWN_DMA;
         r_we      <= 1'b0;
         r_oor     <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         cpu_rdata <= '0;
         dma_rdata <= '0;
         cpu_ack   <= 1'b0;
         dma_ack   <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_owner   <= w_winner;
                  r_we      <= w_selWe;
                  r_oor     <= w_oor;
                  mem_addr  <= w_selAddr[ADDR_WIDTH+1:2];
                  mem_wdata <= w_selWdata;
                  mem_we    <= w_selWe & ~w_oor;
                  r_cnt     <= CNT_W'(MEM_LAT);
                  if (w_oor) begin
                     addr_err <= 1'b1;
                  end
                  r_state   <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               // The write strobe lives only in the first access cycle; the read is captured in the last.
               mem_we <= 1'b0;
               r_cnt  <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  if (!r_we) begin
                     if (r_owner == OWN_CPU) begin
                        cpu_rdata <= r_oor ? '0 : mem_rdata;
                     end else begin
                        dma_rdata <= r_oor ? '0 : mem_rdata;
                     end
                  end
                  if (r_owner == OWN_CPU) begin
                     cpu_ack <= 1'b1;
                  end else begin
                     dma_ack <= 1'b1;
                  end
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: begin
               cpu_ack <= 1'b0;
               dma_ack <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level reference model, randomized
// CPU/DMA requesters, directed corner cases and a MEM_LAT=3 timing instance.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset_b;
   logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dma_req, dma_we, dma_ack;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic [9:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata, mem_rdata;
   logic        owner, addr_err;

   logic        c3Req, c3We, c3Ack, c3Stall, d3Ack, m3We, o3Owner, e3Err;
   logic [31:0] c3Addr, c3Wdata, c3Rdata, d3Rdata, m3Wdata, m3Rdata;
   logic [9:0]  m3Addr;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit memInit = 1'b1;
   bit checkEn = 1'b0;
   bit logEn = 1'b0;
   bit grantLog[$];

   logic [31:0] memArr [1024];
   logic [31:0] mem3Arr [1024];
   logic [31:0] refMem [1024];

   dmem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_LAT(1)) dut (
      .clk(clk), .reset_b(reset_b),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .owner(owner), .addr_err(addr_err)
   );

   dmem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_LAT(3)) dut3 (
      .clk(clk), .reset_b(reset_b),
      .cpu_req(c3Req), .cpu_we(c3We), .cpu_addr(c3Addr), .cpu_wdata(c3Wdata),
      .cpu_rdata(c3Rdata), .cpu_ack(c3Ack), .cpu_stall(c3Stall),
      .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'd0), .dma_wdata(32'd0),
      .dma_rdata(d3Rdata), .dma_ack(d3Ack),
      .mem_addr(m3Addr), .mem_we(m3We), .mem_wdata(m3Wdata), .mem_rdata(m3Rdata),
      .owner(o3Owner), .addr_err(e3Err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Asynchronous-read memories standing in for data_mem.
   always @(posedge clk) begin
      if (memInit) begin
         for (int i = 0; i < 1024; i++) memArr[i] <= 32'd0;
      end else if (mem_we) begin
         memArr[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = memArr[mem_addr];

   always @(posedge clk) begin
      if (memInit) begin
         for (int i = 0; i < 1024; i++) mem3Arr[i] <= 32'd0;
      end else if (m3We) begin
         mem3Arr[m3Addr] <= m3Wdata;
      end
   end
   assign m3Rdata = mem3Arr[m3Addr];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference model: one transaction occupies MEM_LAT+2 cycles (idle sample, access, response).
   int          mRemain;
   bit          mResp, mWin, mWe, mOor;
   logic [31:0] mA, mD, mResult;
   logic        expCpuAck, expDmaAck, expOwner, expErr, expMemWe;
   logic [31:0] expCpuRdata, expDmaRdata, expMemWdata;
   logic [9:0]  expMemAddr;

   always @(posedge clk) begin
      if (memInit) begin
         for (int i = 0; i < 1024; i++) refMem[i] = 32'd0;
      end
      expMemWe = 1'b0;
      if (reset_b) begin
         mRemain = 0; mResp = 1'b0;
         expCpuAck = 1'b0; expDmaAck = 1'b0;
         expCpuRdata = 32'd0; expDmaRdata = 32'd0;
         expOwner = 1'b1; expErr = 1'b0;
      end else begin
         expCpuAck = 1'b0;
         expDmaAck = 1'b0;
         if (mRemain > 0) begin
            mRemain--;
            if (mRemain == 0) begin
               mResp = 1'b1;
               if (!mWin) begin
                  expCpuAck = 1'b1;
                  if (!mWe) expCpuRdata = mResult;
               end else begin
                  expDmaAck = 1'b1;
                  if (!mWe) expDmaRdata = mResult;
               end
            end
         end else if (mResp) begin
            mResp = 1'b0;
         end else if (cpu_req || dma_req) begin
`ifdef DMEM_ARB_RR_EN
            mWin = (cpu_req && dma_req) ? !expOwner : !cpu_req;
`else
            mWin = !cpu_req;
`endif
            mA  = mWin ? dma_addr  : cpu_addr;
            mD  = mWin ? dma_wdata : cpu_wdata;
            mWe = mWin ? dma_we    : cpu_we;
            mOor = (mA >= 32'h0000_1000);
            if (mOor) begin
               expErr = 1'b1;
               mResult = 32'd0;
            end else begin
               if (mWe) refMem[mA[11:2]] = mD;
               mResult = refMem[mA[11:2]];
            end
            expOwner    = mWin;
            expMemWe    = mWe && !mOor;
            expMemAddr  = mA[11:2];
            expMemWdata = mD;
            mRemain     = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("cpu_ack", cpu_ack, expCpuAck);
         checkOutput("dma_ack", dma_ack, expDmaAck);
         checkOutput("cpu_rdata", cpu_rdata, expCpuRdata);
         checkOutput("dma_rdata", dma_rdata, expDmaRdata);
         checkOutput("owner", owner, expOwner);
         checkOutput("addr_err", addr_err, expErr);
         checkOutput("mem_we", mem_we, expMemWe);
         checkOutput("cpu_stall", cpu_stall, cpu_req & ~expCpuAck);
         if (expMemWe) begin
            checkOutput("mem_addr", mem_addr, expMemAddr);
            checkOutput("mem_wdata", mem_wdata, expMemWdata);
         end
      end
      if (logEn) begin
         if (cpu_ack) grantLog.push_back(1'b0);
         if (dma_ack) grantLog.push_back(1'b1);
      end
   end

   // Issue one request and hold it until its ack; returns just after the edge ending RESP.
   task automatic applyStimulus(input bit isDma, input bit we, input logic [31:0] addr, input logic [31:0] data);
      int n;
      bit gotAck;
      if (isDma) begin
         dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = data;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
         gotAck = isDma ? dma_ack : cpu_ack;
      end while (!gotAck && n < 200);
      if (!gotAck) begin
         checks++;
         failures++;
         $display("[TB] FAIL ack_timeout: port %0d got no ack within %0d cycles", isDma, n);
      end
      @(posedge clk);
      #1;
      if (isDma) dma_req = 1'b0;
      else cpu_req = 1'b0;
   endtask

   // Directed MEM_LAT=1 access with hand-computed cycle-by-cycle expectations.
   task automatic directedAccess(input string tag, input bit isDma, input bit we,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input bit wantMemWe, input logic [9:0] wantMemAddr);
      if (isDma) begin
         dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = data;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
      end
      @(negedge clk);
      checkOutput({tag, "_idle_ack"}, isDma ? dma_ack : cpu_ack, 32'd0);
      if (!isDma) checkOutput({tag, "_idle_stall"}, cpu_stall, 32'd1);
      @(negedge clk);
      checkOutput({tag, "_access_ack"}, isDma ? dma_ack : cpu_ack, 32'd0);
      checkOutput({tag, "_access_mem_we"}, mem_we, {31'd0, wantMemWe});
      if (wantMemWe) checkOutput({tag, "_mem_addr"}, mem_addr, {22'd0, wantMemAddr});
      if (!isDma) checkOutput({tag, "_access_stall"}, cpu_stall, 32'd1);
      @(negedge clk);
      checkOutput({tag, "_resp_ack"}, isDma ? dma_ack : cpu_ack, 32'd1);
      checkOutput({tag, "_resp_mem_we"}, mem_we, 32'd0);
      if (!isDma) checkOutput({tag, "_resp_stall"}, cpu_stall, 32'd0);
      @(posedge clk);
      #1;
      if (isDma) dma_req = 1'b0;
      else cpu_req = 1'b0;
   endtask

   function automatic logic [31:0] randAddr();
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
      else a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      return a;
   endfunction

   task automatic randomRequester(input bit isDma, input int count);
      int gap;
      for (int i = 0; i < count; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         applyStimulus(isDma, 1'($urandom_range(0, 1)), randAddr(), $urandom);
      end
   endtask

   task automatic wait3Ack(input string tag, output int ackCyc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!c3Ack && n < 50);
      ackCyc = cyc;
      if (!c3Ack) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_timeout: no ack within %0d cycles", tag, n);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit expOrder[4];
      int t0, tA, tB, tC;
`ifdef DMEM_ARB_RR_EN
      expOrder = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      expOrder = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
      c3Req = 1'b0; c3We = 1'b0; c3Addr = 32'd0; c3Wdata = 32'd0;
      reset_b = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      memInit = 1'b0;
      reset_b = 1'b0;
      checkEn = 1'b1;

      @(negedge clk);
      checkOutput("rst_owner", owner, 32'd1);
      checkOutput("rst_mem_we", mem_we, 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
      checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
      checkOutput("rst_addr_err", addr_err, 32'd0);
      @(posedge clk);
      #1;

      directedAccess("t1_store", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 10'd4);
      directedAccess("t2_load", 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 10'd0);
      checkOutput("t2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

      directedAccess("t4_dma_load", 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 10'd0);
      checkOutput("t4_dma_rdata_ok", dma_rdata, 32'hDEADBEEF);
      directedAccess("t4_dma_oor", 1'b1, 1'b0, 32'h1000, 32'd0, 1'b0, 10'd0);
      checkOutput("t4_dma_rdata_oor", dma_rdata, 32'd0);
      checkOutput("t4_addr_err", addr_err, 32'd1);
      checkOutput("t4_cpu_rdata_kept", cpu_rdata, 32'hDEADBEEF);
      directedAccess("t4_cpu_after", 1'b0, 1'b0, 32'h17, 32'd0, 1'b0, 10'd0);
      checkOutput("t4_addr_err_sticky", addr_err, 32'd1);
      checkOutput("t4_cpu_rdata_word5", cpu_rdata, 32'd0);

      // Reset arrives while a store is in its access cycle.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      reset_b = 1'b1;
      cpu_req = 1'b0;
      @(negedge clk);
      checkOutput("t5_access_mem_we", mem_we, 32'd1);
      @(posedge clk);
      #1;
      reset_b = 1'b0;
      @(negedge clk);
      checkOutput("t5_cpu_ack", cpu_ack, 32'd0);
      checkOutput("t5_mem_we", mem_we, 32'd0);
      checkOutput("t5_mem_addr", mem_addr, 32'd0);
      checkOutput("t5_mem_wdata", mem_wdata, 32'd0);
      checkOutput("t5_owner", owner, 32'd1);
      checkOutput("t5_addr_err", addr_err, 32'd0);
      checkOutput("t5_cpu_rdata", cpu_rdata, 32'd0);
      checkOutput("t5_dma_rdata", dma_rdata, 32'd0);
      @(negedge clk);
      checkOutput("t5_no_late_ack", cpu_ack, 32'd0);
      @(posedge clk);
      #1;

      // Four simultaneous requests from each side.
      grantLog.delete();
      logEn = 1'b1;
      fork
         repeat (4) applyStimulus(1'b0, 1'b0, 32'h20, 32'd0);
         repeat (4) applyStimulus(1'b1, 1'b0, 32'h24, 32'd0);
      join
      logEn = 1'b0;
      checkOutput("t3_grant_count", grantLog.size(), 32'd8);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("t3_grant%0d", i), {31'd0, grantLog[i]}, {31'd0, expOrder[i]});
      end

      fork
         randomRequester(1'b0, 80);
         randomRequester(1'b1, 80);
      join

      // MEM_LAT=3: ack lands MEM_LAT+1 edges after the request is presented; back-to-back accesses are 5 cycles apart.
      @(posedge clk);
      #1;
      c3Req = 1'b1; c3We = 1'b1; c3Addr = 32'h8; c3Wdata = 32'hCAFEF00D;
      t0 = cyc;
      wait3Ack("t6_store", tA);
      checkOutput("t6_store_latency", tA - t0, 32'd4);
      @(posedge clk);
      #1;
      c3We = 1'b0;
      wait3Ack("t6_load1", tB);
      checkOutput("t6_load1_spacing", tB - tA, 32'd5);
      checkOutput("t6_load1_rdata", c3Rdata, 32'hCAFEF00D);
      @(posedge clk);
      #1;
      c3Addr = 32'hC;
      wait3Ack("t6_load2", tC);
      checkOutput("t6_load2_spacing", tC - tB, 32'd5);
      checkOutput("t6_load2_rdata", c3Rdata, 32'd0);
      @(posedge clk);
      #1;
      c3Req = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
